// File: rtl/freq_meter_ctrl.sv
// ============================================================================
// Module   : freq_meter_ctrl
// Brief    : Gated edge counter sequencer: arms, gates, latches and re-arms a
//            saturating edge counter over a programmable window of clk cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_meter_ctrl #(
  parameter int CNT_W       = 24,
  parameter int GATE_W      = 26,
  parameter int GATE_CYCLES = 4_800_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t              state_q, state_d;
  logic                s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
  logic                sat_q, sat_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic                strobe;
  logic [CNT_W-1:0]    edge_nxt;
  logic                sat_nxt;

  assign strobe = s2_q & ~s3_q;

  // Saturating increment: once at all-ones the counter holds and flags sat.
  always_comb begin
    edge_nxt = edge_cnt_q;
    sat_nxt  = sat_q;
    if (strobe) begin
      if (edge_cnt_q == CNT_MAX) begin
        sat_nxt = 1'b1;
      end else begin
        edge_nxt = edge_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    s1_d       = sig_in;
    s2_d       = s1_q;
    s3_d       = s2_q;
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          gate_cnt_d = GATE_LOAD;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
          state_d    = ST_GATE;
        end
      end
      ST_GATE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          edge_cnt_d = edge_nxt;
          sat_d      = sat_nxt;
          if (gate_cnt_q == '0) begin
            // Last gate cycle: its own strobe is included in the result.
            count_d    = edge_nxt;
            overflow_d = sat_nxt;
            done_d     = 1'b1;
            state_d    = ST_DONE;
          end else begin
            gate_cnt_d = gate_cnt_q - 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cont) begin
          gate_cnt_d = GATE_LOAD;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
          state_d    = ST_GATE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_freq_meter_ctrl.sv
// ============================================================================
// Module   : tb_freq_meter_ctrl
// Brief    : Directed self-checking bench for freq_meter_ctrl, four instances
//            with different window / counter sizes sharing one clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_freq_meter_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // a: G=100 CNT_W=24, b: G=20, c: G=64 CNT_W=4, d: G=50
  logic sig_a = 1'b0, start_a = 1'b0, cont_a = 1'b0, abort_a = 1'b0;
  logic sig_b = 1'b0, start_b = 1'b0, cont_b = 1'b0, abort_b = 1'b0;
  logic sig_c = 1'b0, start_c = 1'b0, cont_c = 1'b0, abort_c = 1'b0;
  logic sig_d = 1'b0, start_d = 1'b0, cont_d = 1'b0, abort_d = 1'b0;
  logic busy_a, done_a, ovf_a;
  logic busy_b, done_b, ovf_b;
  logic busy_c, done_c, ovf_c;
  logic busy_d, done_d, ovf_d;
  logic [23:0] count_a, count_b, count_d;
  logic [3:0]  count_c;

  int per_a = 0, per_c = 0, per_d = 0;
  int ph_a = 0, ph_c = 0, ph_d = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  freq_meter_ctrl #(.CNT_W(24), .GATE_W(26), .GATE_CYCLES(100)) u_a (
    .clk(clk), .rst(rst), .sig_in(sig_a), .start(start_a), .cont(cont_a),
    .abort(abort_a), .busy(busy_a), .done(done_a), .count(count_a), .overflow(ovf_a));
  freq_meter_ctrl #(.CNT_W(24), .GATE_W(26), .GATE_CYCLES(20)) u_b (
    .clk(clk), .rst(rst), .sig_in(sig_b), .start(start_b), .cont(cont_b),
    .abort(abort_b), .busy(busy_b), .done(done_b), .count(count_b), .overflow(ovf_b));
  freq_meter_ctrl #(.CNT_W(4), .GATE_W(26), .GATE_CYCLES(64)) u_c (
    .clk(clk), .rst(rst), .sig_in(sig_c), .start(start_c), .cont(cont_c),
    .abort(abort_c), .busy(busy_c), .done(done_c), .count(count_c), .overflow(ovf_c));
  freq_meter_ctrl #(.CNT_W(24), .GATE_W(26), .GATE_CYCLES(50)) u_d (
    .clk(clk), .rst(rst), .sig_in(sig_d), .start(start_d), .cont(cont_d),
    .abort(abort_d), .busy(busy_d), .done(done_d), .count(count_d), .overflow(ovf_d));

  // Periodic stimulus: high for the first half of each period, low otherwise.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (per_a > 0) begin ph_a = (ph_a + 1) % per_a; sig_a = (ph_a < per_a / 2); end
      else sig_a = 1'b0;
      if (per_c > 0) begin ph_c = (ph_c + 1) % per_c; sig_c = (ph_c < per_c / 2); end
      else sig_c = 1'b0;
      if (per_d > 0) begin ph_d = (ph_d + 1) % per_d; sig_d = (ph_d < per_d / 2); end
      else sig_d = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int seen;
    int ndone;

    // Reset with activity on the inputs
    per_a   = 2;
    start_a = 1'b1;
    repeat (2) tick();
    rst     = 1'b0;
    start_a = 1'b0;
    tick();
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_count", count_a, 0);
    check("rst_ovf", ovf_a, 0);
    repeat (3) tick();
    check("rst_no_start", busy_a, 0);

    // Basic count: period 10 over a 100-cycle window gives 10 edges.
    // DONE begins GATE_CYCLES edges after the edge that samples start.
    per_a = 10;
    repeat (20) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    lat = 0;
    for (int k = 1; k <= 101; k++) begin
      tick();
      if (k == 1) check("basic_busy", busy_a, 1);
      if (done_a && lat == 0) lat = k;
      if (k == 100) begin
        check("basic_done", done_a, 1);
        check("basic_count", count_a, 10);
        check("basic_ovf", ovf_a, 0);
      end
      if (k == 101) begin
        check("basic_busy_off", busy_a, 0);
        check("basic_done_off", done_a, 0);
      end
    end
    check("basic_latency", lat, 100);

    // Abort during the gate window
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    seen = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 29) abort_a = 1'b1;
      if (k == 30) begin
        abort_a = 1'b0;
        check("abort_idle", busy_a, 0);
      end
      if (done_a) seen++;
    end
    check("abort_no_done", seen, 0);
    check("abort_count_kept", count_a, 10);

    // Start pulsed while busy must not restart the window
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    lat = 0;
    for (int k = 1; k <= 101; k++) begin
      tick();
      if (k == 40) start_a = 1'b1;
      if (k == 41) start_a = 1'b0;
      if (done_a && lat == 0) lat = k;
    end
    check("ign_start_latency", lat, 100);
    check("ign_start_count", count_a, 10);

    // Window boundary: strobe on the last gate cycle is counted
    sig_b   = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      tick();
      if (k == 17) sig_b = 1'b1;
      if (k == 20) begin
        check("bnd_last_done", done_b, 1);
        check("bnd_last_count", count_b, 1);
      end
    end
    sig_b = 1'b0;
    repeat (5) tick();

    // Strobe landing in DONE is dropped
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      tick();
      if (k == 18) sig_b = 1'b1;
      if (k == 20) begin
        check("bnd_dead_done", done_b, 1);
        check("bnd_dead_count", count_b, 0);
      end
    end
    sig_b = 1'b0;

    // Saturation: 32 edges into a 4-bit counter
    per_c = 2;
    repeat (6) tick();
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 64) begin
        check("sat_done", done_c, 1);
        check("sat_count", count_c, 15);
        check("sat_ovf", ovf_c, 1);
      end
    end
    per_c = 0;
    repeat (6) tick();
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 64) begin
        check("quiet_done", done_c, 1);
        check("quiet_count", count_c, 0);
        check("quiet_ovf", ovf_c, 0);
      end
    end

    // Continuous mode: one result every 51 cycles, cont dropped before the third
    per_d  = 5;
    cont_d = 1'b1;
    repeat (10) tick();
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 160; k++) begin
      tick();
      if (k == 120) cont_d = 1'b0;
      if (done_d) begin
        ndone++;
        check("cont_done_time", k, 50 + 51 * (ndone - 1));
        check("cont_count", count_d, 10);
      end
      if (k == 153) check("cont_stop_busy", busy_d, 0);
    end
    check("cont_ndone", ndone, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/freq_meter_ctrl.md
# freq_meter_ctrl

Gated frequency-measurement controller for the iCE40 UP5K test design. It runs in the internal-oscillator domain (`SB_HFOSC` output, nominally 48 MHz) and counts rising edges of an asynchronous external signal (the crystal input or any pin) over a programmable window of `clk` cycles. Board-level logic uses the latched count to check the crystal against the internal oscillator and to drive status LEDs. The block is the sequencer for the free-running edge counter: it arms, gates, latches and re-arms that counter.

## Interface
Parameters:
- `CNT_W`, 24: width of the edge counter and the `count` result.
- `GATE_W`, 26: width of the gate-window down-counter.
- `GATE_CYCLES`, 4_800_000: window length in `clk` cycles (100 ms at 48 MHz). Legal range is 2 .. 2^GATE_W−1.

Ports:
- `clk`, in, 1: sole clock. All state changes on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `sig_in`, in, 1: asynchronous signal under measurement.
- `start`, in, 1: single-shot request, sampled in IDLE only.
- `cont`, in, 1: continuous mode. Sampled in DONE.
- `abort`, in, 1: cancel the measurement in progress.
- `busy`, out, 1: high in GATE and DONE.
- `done`, out, 1: one-cycle pulse when `count` is updated.
- `count`, out, CNT_W: edges seen in the last completed window. Held between windows.
- `overflow`, out, 1: the last completed window saturated the edge counter. Updated together with `count`.

## Operation
- **Input conditioning.** `sig_in` passes through a 2-flop synchronizer followed by a third flop. The edge strobe is `s2 & ~s3`. The strobe runs in every state and is flushed to 0 by reset.
- **States:** IDLE, GATE, DONE. Encoding is free.
- **IDLE:**
  - `busy`=0.
  - `start`=1 loads gate_cnt = GATE_CYCLES−1, clears edge_cnt and the internal sat flag, then moves to GATE.
- **GATE:**
  - Each cycle with the edge strobe high: edge_cnt += 1.
  - At all-ones, edge_cnt holds and sets sat. It never wraps.
  - gate_cnt decrements each cycle. The cycle where gate_cnt==0 is the last GATE cycle, and its strobe is counted. The next state is DONE.
- **DONE (exactly one cycle):**
  - `count` ← edge_cnt, `overflow` ← sat, `done`=1.
  - An edge strobe in this cycle is dropped (dead cycle).
  - If `cont`=1: reload gate_cnt, clear edge_cnt and sat, go to GATE.
  - Otherwise go to IDLE.
- **abort:**
  - In GATE or DONE, `abort`=1 forces IDLE next cycle. No `done` pulse; `count` and `overflow` are unchanged.
  - Abort wins over DONE's latch and over `cont`.
  - In IDLE, `abort` wins over `start` (stay IDLE).
- **`start` outside IDLE** is ignored; it is not queued.
- **`cont` in IDLE** has no effect. Continuous mode always begins with `start`.
- **Reset mid-operation:** identical to the reset state. Any window in progress is discarded.

## Timing
- **Reset values:** state=IDLE, `busy`=0, `done`=0, `count`=0, `overflow`=0, synchronizer flops=0, gate_cnt=0, edge_cnt=0.
- **Single-shot sequence**, with `start` sampled high at edge T:
  - `busy`=1 from T+1.
  - GATE occupies cycles T+1 .. T+GATE_CYCLES (exactly GATE_CYCLES cycles).
  - DONE occurs at cycle T+GATE_CYCLES+1, with `done`=1 and the new `count` visible in the same cycle.
  - `busy`=0 from T+GATE_CYCLES+2.
- **Continuous-mode period:** GATE_CYCLES+1 cycles per result (GATE_CYCLES gate cycles plus 1 dead cycle).
- **Pin-to-strobe latency:** 3 `clk` edges. A pin edge is attributed to the window in which its strobe lands.
- **Measurable input rate:** at most `clk`/2. Faster input aliases, and the bench must not expect correct counts above that rate.
- **Arithmetic:** all counters are unsigned. The gate compare is against zero only. `count` is never a partial value.

## Test plan
1. **Reset:** assert `rst` for 2 cycles with `sig_in` toggling and `start`=1 → `busy`=0, `done`=0, `count`=0, `overflow`=0. `start` is not acted on after release until sampled again.
2. **Basic count:** GATE_CYCLES=100, `sig_in` period 10 clk, then `start` pulse → `done` exactly 101 cycles after the start edge, `count`=10, `overflow`=0, `busy`=0 on the following cycle.
3. **Window boundaries:** GATE_CYCLES=20 with a single strobe forced on the last GATE cycle → `count`=1. Repeat with the strobe in the DONE cycle → `count`=0.
4. **Saturation:** CNT_W=4, GATE_CYCLES=64, `sig_in` period 2 → `count`=15, `overflow`=1. A following window with no edges gives `count`=0, `overflow`=0.
5. **Continuous mode:** `cont`=1, GATE_CYCLES=50, `sig_in` period 5 → `done` pulses every 51 cycles, each with `count`=10. Dropping `cont` before a DONE returns the block to IDLE after that result.
6. **Abort and ignored start:**
   - `abort` at GATE cycle 30 → IDLE next cycle, no `done`, `count` retains the previous value.
   - `start` pulsed while `busy` → window timing unchanged from the original start.
